// File: rtl/e203_exu_longp_retire_pkg.sv
// ---------------------------------------------------------------------------
// e203_exu_longp_retire_pkg
// Shared widths and helpers for the long-pipe retire sequencer.
//   LP_*       : default widths (tag, OITF depth, XLEN, register index, PC)
//   drain_kind : classifies what the buffered entry must do to leave the block
// ---------------------------------------------------------------------------
package e203_exu_longp_retire_pkg;

    localparam int LP_SRC_NUM    = 2;
    localparam int LP_ITAG_W     = 1;
    localparam int LP_OITF_DEPTH = 1 << LP_ITAG_W;
    localparam int LP_XLEN       = 32;
    localparam int LP_RFIDX_W    = 5;
    localparam int LP_PC_W       = 32;

    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,   // buffer empty
        DRAIN_WBCK = 2'd1,   // register-file write pending
        DRAIN_EXCP = 2'd2,   // exception request pending
        DRAIN_NONE = 2'd3    // nothing to write, retires immediately
    } drain_kind_e;

    // An error always wins over the register write: a faulting instruction
    // must never update the register file.
    function automatic drain_kind_e drain_kind(input logic vld,
                                               input logic err,
                                               input logic rdwen);
        drain_kind_e k;
        if (!vld)       k = DRAIN_IDLE;
        else if (err)   k = DRAIN_EXCP;
        else if (rdwen) k = DRAIN_WBCK;
        else            k = DRAIN_NONE;
        return k;
    endfunction

endpackage

// File: rtl/e203_exu_longp_retire_buf.sv
// ---------------------------------------------------------------------------
// e203_exu_longp_retire_buf
// One-entry holding stage between the tag-matched source and writeback.
//   clk, rst_n        : clock, asynchronous active-low reset (valid only)
//   set               : load the payload and mark the entry valid
//   clr               : entry has drained; mark it empty
//   ld_*              : payload to capture on set
//   buf_vld, buf_*    : current entry state
// Payload registers have a load enable only; their contents are meaningless
// while buf_vld is low, so they carry no reset.
// ---------------------------------------------------------------------------
module e203_exu_longp_retire_buf
    import e203_exu_longp_retire_pkg::*;
#(
    parameter int XLEN    = LP_XLEN,
    parameter int RFIDX_W = LP_RFIDX_W,
    parameter int PC_W    = LP_PC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               set,
    input  logic               clr,
    input  logic [XLEN-1:0]    ld_wdat,
    input  logic [RFIDX_W-1:0] ld_rdidx,
    input  logic               ld_rdwen,
    input  logic               ld_err,
    input  logic [PC_W-1:0]    ld_pc,
    output logic               buf_vld,
    output logic [XLEN-1:0]    buf_wdat,
    output logic [RFIDX_W-1:0] buf_rdidx,
    output logic               buf_rdwen,
    output logic               buf_err,
    output logic [PC_W-1:0]    buf_pc
);

    // set and clr are never high together: a capture requires an empty
    // entry while a drain requires a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld <= 1'b0;
        end else if (set) begin
            buf_vld <= 1'b1;
        end else if (clr) begin
            buf_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (set) begin
            buf_wdat  <= ld_wdat;
            buf_rdidx <= ld_rdidx;
            buf_rdwen <= ld_rdwen;
            buf_err   <= ld_err;
            buf_pc    <= ld_pc;
        end
    end

endmodule

// File: rtl/e203_exu_longp_retire.sv
// ---------------------------------------------------------------------------
// e203_exu_longp_retire
// In-order retire / writeback sequencer for long-pipe instructions.
//   src_i_*        : per-source completions (valid/ready, tag, data, error)
//   oitf_*         : oldest OITF entry (empty flag, tag, rd index/enable, PC)
//   oitf_ret_ena   : one-cycle pop of the oldest OITF entry
//   wbck_o_*       : register-file write request
//   excp_o_*       : exception request toward commit
//   busy           : holding buffer occupied
// Only the source whose tag equals the OITF retire pointer may hand over its
// result, so completions leave in program order. The OITF entry is popped
// only once the result has actually left, keeping dispatch hazard checks
// conservative.
// ---------------------------------------------------------------------------
module e203_exu_longp_retire
    import e203_exu_longp_retire_pkg::*;
#(
    parameter int SRC_NUM = LP_SRC_NUM,
    parameter int ITAG_W  = LP_ITAG_W,
    parameter int XLEN    = LP_XLEN,
    parameter int RFIDX_W = LP_RFIDX_W,
    parameter int PC_W    = LP_PC_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SRC_NUM-1:0]        src_i_valid,
    output logic [SRC_NUM-1:0]        src_i_ready,
    input  logic [SRC_NUM*ITAG_W-1:0] src_i_itag,
    input  logic [SRC_NUM*XLEN-1:0]   src_i_wdat,
    input  logic [SRC_NUM-1:0]        src_i_err,
    input  logic                      oitf_empty,
    input  logic [ITAG_W-1:0]         oitf_ret_ptr,
    input  logic [RFIDX_W-1:0]        oitf_ret_rdidx,
    input  logic                      oitf_ret_rdwen,
    input  logic [PC_W-1:0]           oitf_ret_pc,
    output logic                      oitf_ret_ena,
    output logic                      wbck_o_valid,
    input  logic                      wbck_o_ready,
    output logic [XLEN-1:0]           wbck_o_wdat,
    output logic [RFIDX_W-1:0]        wbck_o_rdidx,
    output logic                      excp_o_valid,
    input  logic                      excp_o_ready,
    output logic [PC_W-1:0]           excp_o_pc,
    output logic                      busy
);

    logic               buf_vld;
    logic [XLEN-1:0]    buf_wdat;
    logic [RFIDX_W-1:0] buf_rdidx;
    logic               buf_rdwen;
    logic               buf_err;
    logic [PC_W-1:0]    buf_pc;

    logic [SRC_NUM-1:0] elig;
    logic [XLEN-1:0]    sel_wdat;
    logic               sel_err;
    logic               sel_found;
    logic               cap;
    logic               drain_done;
    drain_kind_e        dk;

    // Tag-match select: a non-matching source simply sees ready low and keeps
    // its completion until its tag becomes the oldest.
    always_comb begin
        elig        = '0;
        src_i_ready = '0;
        sel_wdat    = '0;
        sel_err     = 1'b0;
        sel_found   = 1'b0;
        for (int k = 0; k < SRC_NUM; k++) begin
            elig[k] = src_i_valid[k] & ~oitf_empty & ~buf_vld
                    & (src_i_itag[k*ITAG_W +: ITAG_W] == oitf_ret_ptr);
        end
        for (int k = 0; k < SRC_NUM; k++) begin
            if (!sel_found && elig[k]) begin
                src_i_ready[k] = 1'b1;
                sel_wdat       = src_i_wdat[k*XLEN +: XLEN];
                sel_err        = src_i_err[k];
                sel_found      = 1'b1;
            end
        end
    end

    assign cap = sel_found;

    // ---- capture stage: completion + oldest-entry info into the buffer ----
    e203_exu_longp_retire_buf #(
        .XLEN    (XLEN),
        .RFIDX_W (RFIDX_W),
        .PC_W    (PC_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .set       (cap),
        .clr       (drain_done),
        .ld_wdat   (sel_wdat),
        .ld_rdidx  (oitf_ret_rdidx),
        .ld_rdwen  (oitf_ret_rdwen),
        .ld_err    (sel_err),
        .ld_pc     (oitf_ret_pc),
        .buf_vld   (buf_vld),
        .buf_wdat  (buf_wdat),
        .buf_rdidx (buf_rdidx),
        .buf_rdwen (buf_rdwen),
        .buf_err   (buf_err),
        .buf_pc    (buf_pc)
    );

    // ---- drain stage: writeback / exception / silent retire ----
    assign dk           = drain_kind(buf_vld, buf_err, buf_rdwen);
    assign wbck_o_valid = (dk == DRAIN_WBCK);
    assign excp_o_valid = (dk == DRAIN_EXCP);

    assign drain_done = (wbck_o_valid & wbck_o_ready)
                      | (excp_o_valid & excp_o_ready)
                      | (dk == DRAIN_NONE);

    assign oitf_ret_ena = drain_done;
    assign busy         = buf_vld;

    // Payload is zeroed whenever its valid is low so that reset and idle
    // present clean zeros instead of stale buffer contents.
    assign wbck_o_wdat  = wbck_o_valid ? buf_wdat  : '0;
    assign wbck_o_rdidx = wbck_o_valid ? buf_rdidx : '0;
    assign excp_o_pc    = excp_o_valid ? buf_pc    : '0;

endmodule
